// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns PC and IR, runs a req/ack fetch against
// instruction memory with a timeout, and decodes the IR fields.
module fetch_unit #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PC_Write,
  input  logic              IR_Write,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       ir,
  output logic [6:0]        opcode,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        rd,
  output logic [31:0]       imm_i,
  output logic [31:0]       imm_u,
  output logic              busy,
  output logic              fetch_done,
  output logic              ir_drop,
  output logic              fetch_fault
);

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [7:0]  CNT_LST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       ir_q, ir_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;
  logic              fault_q, fault_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      ir_q    <= NOP;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    fault_d = fault_q;
    pc_d    = PC_Write ? pc_q + ADDR_W'(4) : pc_q;
    unique case (state_q)
      IDLE: begin
        if (IR_Write) begin
          addr_d  = pc_q;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        drop_d = IR_Write;
        // An ack on the expiry edge takes priority over the timeout.
        if (imem_ack) begin
          ir_d    = imem_rdata;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LST) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req    = (state_q == WAIT);
  assign busy        = (state_q == WAIT);
  assign imem_addr   = addr_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign fetch_done  = done_q;
  assign ir_drop     = drop_q;
  assign fetch_fault = fault_q;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign rd     = ir_q[11:7];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_u  = {ir_q[31:12], 12'b0};

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected IR words queued when memory
// responds, popped and compared when fetch_done pulses.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, ir_write, ack;
  logic [31:0] rdata;
  logic        req, busy, done, drop, fault;
  logic [31:0] addr, pc, ir, imm_i, imm_u;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;

  logic        w_pc_write, w_ir_write, w_ack;
  logic [31:0] w_rdata;
  logic        w_req, w_busy, w_done, w_drop, w_fault;
  logic [31:0] w_addr, w_pc, w_ir, w_imm_i, w_imm_u;
  logic [6:0]  w_opcode, w_funct7;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1, w_rs2, w_rd;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0100), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .PC_Write(pc_write), .IR_Write(ir_write),
    .imem_req(req), .imem_addr(addr), .imem_rdata(rdata), .imem_ack(ack),
    .pc(pc), .ir(ir), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm_i(imm_i), .imm_u(imm_u),
    .busy(busy), .fetch_done(done), .ir_drop(drop), .fetch_fault(fault)
  );

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .TIMEOUT(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .PC_Write(w_pc_write), .IR_Write(w_ir_write),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata), .imem_ack(w_ack),
    .pc(w_pc), .ir(w_ir), .opcode(w_opcode), .funct3(w_funct3), .funct7(w_funct7),
    .rs1(w_rs1), .rs2(w_rs2), .rd(w_rd), .imm_i(w_imm_i), .imm_u(w_imm_u),
    .busy(w_busy), .fetch_done(w_done), .ir_drop(w_drop), .fetch_fault(w_fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic respond(input logic [31:0] word);
    ack   = 1'b1;
    rdata = word;
    exp_q.push_back(word);
  endtask

  task automatic sb_check(input string tag);
    check({tag, "_done"}, 32'(done), 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb: observed empty queue expected entry", tag);
    end else begin
      check({tag, "_ir"}, ir, exp_q.pop_front());
    end
  endtask

  initial begin
    logic [31:0] b2b [3];
    b2b[0] = 32'h0010_0093; b2b[1] = 32'h0020_0113; b2b[2] = 32'h0030_0193;

    rst_n = 1'b0; pc_write = 1'b0; ir_write = 1'b0; ack = 1'b0; rdata = '0;
    w_pc_write = 1'b0; w_ir_write = 1'b0; w_ack = 1'b0; w_rdata = '0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();

    // Reset release
    check("rst_pc", pc, 32'h100);
    check("rst_ir", ir, 32'h13);
    check("rst_opcode", 32'(opcode), 32'h13);
    check("rst_req", 32'(req), 0);
    check("rst_flags", {28'd0, busy, done, drop, fault}, 0);
    check("rst_addr", addr, 32'h100);

    // PC wrap on the second instance
    check("wrap_pc_init", w_pc, 32'hFFFF_FFFC);
    w_pc_write = 1'b1; step(); w_pc_write = 1'b0;
    check("wrap_pc", w_pc, 32'h0);

    // Basic fetch with PC_Write in the same cycle and again during WAIT
    ir_write = 1'b1; pc_write = 1'b1; step();
    ir_write = 1'b0;
    check("bf_req", 32'(req), 1);
    check("bf_busy", 32'(busy), 1);
    check("bf_addr0", addr, 32'h100);
    check("bf_pc0", pc, 32'h104);
    step(); pc_write = 1'b0;
    check("bf_pc1", pc, 32'h108);
    check("bf_addr1", addr, 32'h100);
    step();
    check("bf_addr2", addr, 32'h100);
    check("bf_req2", 32'(req), 1);
    respond(32'h0050_0093); step(); ack = 1'b0;
    sb_check("bf");
    check("bf_rd", 32'(rd), 1);
    check("bf_imm_i", imm_i, 32'd5);
    check("bf_req_off", 32'(req), 0);
    step();
    check("bf_pulse", 32'(done), 0);

    // Negative immediates
    ir_write = 1'b1; step(); ir_write = 1'b0;
    check("im_addr", addr, 32'h108);
    respond(32'hFFF0_0113); step(); ack = 1'b0;
    sb_check("im");
    check("im_imm_i", imm_i, 32'hFFFF_FFFF);
    check("im_imm_u", imm_u, 32'hFFF0_0000);
    check("im_rd", 32'(rd), 2);

    // Ack while idle is ignored
    ack = 1'b1; rdata = 32'h1234_5678; step(); ack = 1'b0;
    check("idle_ack_ir", ir, 32'hFFF0_0113);
    check("idle_ack_done", 32'(done), 0);

    // Ack on the timeout edge wins
    ir_write = 1'b1; step(); ir_write = 1'b0;
    step(); step(); step();
    check("to_req", 32'(req), 1);
    respond(32'h00A0_0513); step(); ack = 1'b0;
    sb_check("to");
    check("to_fault", 32'(fault), 0);
    check("to_req_off", 32'(req), 0);
    step();
    check("to_fault2", 32'(fault), 0);

    // Back-to-back zero-latency fetches: fetch_done every 2 cycles
    for (int i = 0; i < 3; i++) begin
      ir_write = 1'b1; step(); ir_write = 1'b0;
      check("b2b_gap", 32'(done), 0);
      check("b2b_req", 32'(req), 1);
      respond(b2b[i]); step(); ack = 1'b0;
      sb_check("b2b");
    end
    step();

    // Timeout fault with overlapping IR_Write
    ir_write = 1'b1; step(); ir_write = 1'b0;
    check("ft_req0", 32'(req), 1);
    step();
    ir_write = 1'b1; step(); ir_write = 1'b0;
    check("ft_drop", 32'(drop), 1);
    check("ft_req2", 32'(req), 1);
    step();
    check("ft_drop_pulse", 32'(drop), 0);
    check("ft_req3", 32'(req), 1);
    check("ft_nofault_yet", 32'(fault), 0);
    step();
    check("ft_req_off", 32'(req), 0);
    check("ft_fault", 32'(fault), 1);
    check("ft_ir", ir, 32'h0030_0193);
    check("ft_done", 32'(done), 0);
    repeat (3) step();
    check("ft_sticky", 32'(fault), 1);

    // Reset mid-fetch with a concurrent ack
    ir_write = 1'b1; step(); ir_write = 1'b0;
    check("rm_busy", 32'(busy), 1);
    rst_n = 1'b0; ack = 1'b1; rdata = 32'hDEAD_BEEF; step();
    ack = 1'b0; rst_n = 1'b1;
    check("rm_ir", ir, 32'h13);
    check("rm_req", 32'(req), 0);
    check("rm_pc", pc, 32'h100);
    check("rm_addr", addr, 32'h100);
    check("rm_flags", {28'd0, busy, done, drop, fault}, 0);

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch unit for the multi-cycle RV32I core: the datapath-side responder to the control unit's `PC_Write` / `IR_Write` strobes. It owns the PC and IR and runs a request/acknowledge fetch against instruction memory. It decodes the IR fields (`opcode`, `funct3`, `funct7`, register indices, immediates) that feed back into the control unit's state machine.

## Interface
- `ADDR_W`, 32, PC / memory address width.
- `RESET_PC`, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.
- `TIMEOUT`, 16, maximum cycles to wait for `imem_ack` before a fault; valid range 1..255.

Ports. Clock `clk`; reset `rst_n` is synchronous and active-low.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `PC_Write`  in  1  control unit strobe: PC <= PC + 4.
- `IR_Write`  in  1  control unit strobe: fetch the word at the current PC into the IR.
- `imem_req`  out  1  memory request, held until ack or timeout.
- `imem_addr`  out  ADDR_W  fetch address, stable while `imem_req` = 1.
- `imem_rdata`  in  32  instruction word, valid when `imem_ack` = 1.
- `imem_ack`  in  1  one-cycle acknowledge; ignored unless `imem_req` = 1.
- `pc`  out  ADDR_W  current PC.
- `ir`  out  32  instruction register.
- `opcode`  out  7  `ir[6:0]`.
- `funct3`  out  3  `ir[14:12]`.
- `funct7`  out  7  `ir[31:25]`.
- `rs1`, `rs2`, `rd`  out  5 each  `ir[19:15]`, `ir[24:20]`, `ir[11:7]`.
- `imm_i`  out  32  sign-extended `ir[31:20]`.
- `imm_u`  out  32  `{ir[31:12], 12'b0}`.
- `busy`  out  1  high in WAIT.
- `fetch_done`  out  1  one-cycle pulse when the IR is loaded.
- `ir_drop`  out  1  one-cycle pulse when `IR_Write` arrives while busy.
- `fetch_fault`  out  1  sticky timeout flag, cleared only by reset.

## Operation
- Two-state FSM:
  - IDLE: `imem_req` = 0.
    - `IR_Write` = 1 → register `imem_addr` <= PC, clear the wait counter, go to WAIT.
  - WAIT: `imem_req` = 1.
    - `imem_ack` = 1 → IR <= `imem_rdata`, pulse `fetch_done`, go to IDLE.
    - Otherwise the counter increments. If the counter reaches TIMEOUT−1 without an ack → set `fetch_fault`, leave the IR unchanged, go to IDLE.
- `PC_Write` is honoured in either state: PC <= (PC + 4) mod 2^ADDR_W. 0xFFFF_FFFC wraps to 0.
- `PC_Write` and `IR_Write` in the same IDLE cycle: the fetch uses the old PC; the PC still increments.
- `PC_Write` during WAIT changes `pc` only. `imem_addr` is a separate register and does not change.
- `IR_Write` during WAIT: ignored, `ir_drop` pulses, the fetch in flight continues.
- An ack arriving on the same edge that the timeout expires wins: IR loads, no fault.
- Decode outputs are combinational from the IR only and never depend on `imem_rdata` directly.
- Reset values (`rst_n` = 0 at an edge, including mid-fetch):
  - state IDLE, counter 0, PC = RESET_PC, `imem_addr` = RESET_PC;
  - IR = 32'h0000_0013 (NOP), giving `opcode` = 7'b0010011;
  - `imem_req`, `busy`, `fetch_done`, `ir_drop`, `fetch_fault` = 0.
  - An ack arriving in the reset cycle is discarded.

## Timing
- All state is registered on the rising edge of `clk`. No combinational path runs from `imem_ack` to `imem_req`.
- `IR_Write` sampled at edge k → `imem_req` = 1 and `busy` = 1 from edge k to edge k+1.
- Ack sampled at edge m → new IR and `fetch_done` = 1 during cycle m..m+1 → `imem_req` = 0 after edge m.
- Minimum fetch, with ack in the first request cycle: IR valid 2 edges after `IR_Write` is sampled.
- A new `IR_Write` may be sampled in the same cycle `fetch_done` is high (back-to-back fetches, one idle-gap-free request per 2 cycles minimum).
- PC update takes 1 cycle: `pc` reflects `PC_Write` after the next edge.

## Test plan
- Reset release:
  - Stimulus: RESET_PC = 0x100, no strobes for 5 cycles.
  - Required: `pc` = 0x100, `ir` = 0x00000013, `opcode` = 0x13, all flags 0, `imem_req` = 0.
- Basic fetch:
  - Stimulus: `IR_Write` + `PC_Write` together at PC = 0x100; memory acks after 3 cycles with 0x00500093.
  - Required: `imem_addr` = 0x100 throughout; `pc` = 0x104; IR = 0x00500093; `rd` = 1, `imm_i` = 5; `fetch_done` is a single pulse.
- Fault and overlap:
  - Stimulus: TIMEOUT = 4, no ack; a second `IR_Write` during WAIT.
  - Required: `ir_drop` pulses once; `imem_req` drops after 4 request cycles; `fetch_fault` = 1 and stays high; IR unchanged.
- Wrap and immediates:
  - Stimulus: PC = 0xFFFF_FFFC, `PC_Write`.
  - Required: `pc` = 0.
  - Stimulus: fetch 0xFFF00113.
  - Required: `imm_i` = 0xFFFF_FFFF, `imm_u` = 0xFFF0_0000.
- Reset mid-fetch:
  - Stimulus: `rst_n` low in WAIT, with `imem_ack` asserted in the same cycle.
  - Required: IR stays NOP, `imem_req` = 0 next cycle, `pc` = RESET_PC.
- Timing edge cases:
  - Stimulus: ack on the edge where the timeout expires.
  - Required: IR loads, `fetch_fault` stays 0.
  - Stimulus: back-to-back fetches with zero-latency ack.
  - Required: `fetch_done` every 2 cycles.
